// File: rtl/write_arb_pkg.sv
// Shared definitions for the packet-granular write arbiter: FSM encoding,
// default widths and the grant-index width helper.
package write_arb_pkg;

  localparam int DEF_NUM_PORTS    = 16;
  localparam int DEF_DATA_WIDTH   = 256;
  localparam int DEF_PRIO_WIDTH   = 3;
  localparam int DEF_WEIGHT_WIDTH = 4;

  // IDLE arbitrates between packets, XFER streams one packet from sop to eop.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Width of a port index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrr_credit_sched.sv
// Weighted round-robin scheduler: per-port credits, bulk reload when no ready
// port has credit left, and a rotating first-eligible search from rr_ptr.
// The grant is combinational; credits and rr_ptr advance only on take.
module wrr_credit_sched
  import write_arb_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  localparam int SEL_WIDTH   = sel_width(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              ready,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_p,
  input  logic                              take,
  output logic [SEL_WIDTH-1:0]              grant
);

  logic [WEIGHT_WIDTH-1:0] credit     [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0] eff_credit [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0] wt;
  logic [NUM_PORTS-1:0]    has_credit;
  logic [NUM_PORTS-1:0]    elig;
  logic [SEL_WIDTH-1:0]    rr_ptr;
  logic                    reload;
  logic                    found;
  int                      idx;

  // Reload-aware eligibility, then first eligible port at or after rr_ptr.
  always_comb begin
    has_credit = '0;
    elig       = '0;
    wt         = '0;
    grant      = rr_ptr;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      has_credit[i] = (credit[i] != '0);
    end
    reload = ~|(ready & has_credit);
    for (int i = 0; i < NUM_PORTS; i++) begin
      wt            = weight_p[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      eff_credit[i] = reload ? ((wt == '0) ? WEIGHT_WIDTH'(1) : wt) : credit[i];
      elig[i]       = ready[i] && (eff_credit[i] != '0);
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && elig[idx]) begin
        grant = SEL_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

  // Commit the grant: charge one credit, keep the burst or move past the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) credit[i] <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        credit[i] <= (SEL_WIDTH'(i) == grant) ? eff_credit[i] - WEIGHT_WIDTH'(1) : eff_credit[i];
      end
      if (eff_credit[grant] == WEIGHT_WIDTH'(1)) begin
        rr_ptr <= (int'(grant) == NUM_PORTS - 1) ? '0 : grant + SEL_WIDTH'(1);
      end else begin
        rr_ptr <= grant;
      end
    end
  end

endmodule

// File: rtl/write_arbiter_wrr.sv
// N:1 packet write arbiter toward the SRAM write path. Strict-priority or WRR
// selection in IDLE, grant held from sop to eop in XFER, one output register.
// Handshake: a word moves from port g when vld[g] & next_data[g]; the output
// word moves downstream when out_vld & out_ready; next_data[g] is raised only
// when the output register is empty or being drained this cycle.
module write_arbiter_wrr
  import write_arb_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PRIO_WIDTH   = DEF_PRIO_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  localparam int SEL_WIDTH   = sel_width(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sp0_wrr1,
  input  logic [NUM_PORTS-1:0]              ready,
  input  logic [NUM_PORTS-1:0]              sop,
  input  logic [NUM_PORTS-1:0]              eop,
  input  logic [NUM_PORTS-1:0]              vld,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   data_in_p,
  input  logic [NUM_PORTS*PRIO_WIDTH-1:0]   priority_p,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_p,
  input  logic                              out_ready,
  output logic [NUM_PORTS-1:0]              next_data,
  output logic [DATA_WIDTH-1:0]             selected_data_out,
  output logic                              out_vld,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [SEL_WIDTH-1:0]              grant_port,
  output logic                              busy
);

  arb_state_t              state, state_nxt;
  logic [SEL_WIDTH-1:0]    sp_sel, wrr_sel, arb_sel;
  logic [PRIO_WIDTH-1:0]   sp_best;
  logic                    sp_found;
  logic                    arb_take, pop, load;

  // Strict priority: highest code wins, strict '>' keeps ties on the lowest index.
  always_comb begin
    sp_sel   = '0;
    sp_best  = '0;
    sp_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ready[i] && (!sp_found || priority_p[i*PRIO_WIDTH +: PRIO_WIDTH] > sp_best)) begin
        sp_sel   = SEL_WIDTH'(i);
        sp_best  = priority_p[i*PRIO_WIDTH +: PRIO_WIDTH];
        sp_found = 1'b1;
      end
    end
  end

  wrr_credit_sched #(
    .NUM_PORTS    (NUM_PORTS),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_wrr (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .weight_p (weight_p),
    .take     (arb_take & sp0_wrr1),
    .grant    (wrr_sel)
  );

  assign arb_sel = sp0_wrr1 ? wrr_sel : sp_sel;

  // FSM next state plus pop/load strobes for the granted port.
  always_comb begin
    state_nxt = state;
    next_data = '0;
    busy      = 1'b0;
    arb_take  = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|ready) begin
          arb_take  = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        busy                  = 1'b1;
        pop                   = !out_vld || out_ready;
        next_data[grant_port] = pop;
        load                  = pop && vld[grant_port];
        if (load && eop[grant_port]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and grant index latched at arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_port <= '0;
    end else begin
      state <= state_nxt;
      if (arb_take) grant_port <= arb_sel;
    end
  end

  // Output register: load on pop of a valid word, hold under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      selected_data_out <= '0;
      out_vld           <= 1'b0;
      out_sop           <= 1'b0;
      out_eop           <= 1'b0;
    end else if (load) begin
      selected_data_out <= data_in_p[int'(grant_port)*DATA_WIDTH +: DATA_WIDTH];
      out_sop           <= sop[grant_port];
      out_eop           <= eop[grant_port];
      out_vld           <= 1'b1;
    end else if (out_ready) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_arbiter_wrr.sv
// Bench for write_arbiter_wrr: per-port packet sources, a packet-order reference
// model computed up front from the arbitration rules, and an output scoreboard.
module tb_write_arbiter_wrr;
  import write_arb_pkg::*;

  localparam int NP = 16;
  localparam int DW = 32;
  localparam int PW = 3;
  localparam int WW = 4;
  localparam int SW = 4;
  localparam int QW = DW + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            sp0_wrr1;
  logic [NP-1:0]   ready, sop, eop, vld;
  logic [NP*DW-1:0] data_in_p;
  logic [NP*PW-1:0] priority_p;
  logic [NP*WW-1:0] weight_p;
  logic            out_ready;
  logic [NP-1:0]   next_data;
  logic [DW-1:0]   selected_data_out;
  logic            out_vld, out_sop, out_eop, busy;
  logic [SW-1:0]   grant_port;

  write_arbiter_wrr #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .PRIO_WIDTH(PW), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .ready(ready), .sop(sop), .eop(eop),
    .vld(vld), .data_in_p(data_in_p), .priority_p(priority_p), .weight_p(weight_p),
    .out_ready(out_ready), .next_data(next_data), .selected_data_out(selected_data_out),
    .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop), .grant_port(grant_port),
    .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [QW-1:0] port_q [NP][$];
  int            plen   [NP][$];
  logic [QW-1:0] exp_q [$];
  int            exp_port_q [$];

  int   bubble_pct = 0;
  int   bp_pct     = 0;
  int   bp_hold    = 0;
  int   total_pops = 0;
  int   seq        = 0;
  int   m_credit [NP];
  int   m_ptr    = 0;
  logic m_busy   = 1'b0;
  logic m_out_vld = 1'b0;
  logic hold     = 1'b0;
  logic [QW-1:0] last_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive port heads, ready and out_ready for the coming cycle
  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (port_q[i].size() > 0) begin
        {sop[i], eop[i], data_in_p[i*DW +: DW]} = port_q[i][0];
        vld[i]   = ($urandom_range(99) >= bubble_pct);
        ready[i] = 1'b1;
      end else begin
        sop[i] = 1'b0; eop[i] = 1'b0; vld[i] = 1'b0; ready[i] = 1'b0;
        data_in_p[i*DW +: DW] = '0;
      end
    end
    if (bp_hold > 0) begin
      out_ready = 1'b0;
      bp_hold--;
    end else begin
      out_ready = ($urandom_range(99) >= bp_pct);
    end
  endtask

  task automatic load_pkt(input int port, input int len);
    for (int w = 0; w < len; w++) begin
      port_q[port].push_back({(w == 0), (w == len - 1), 8'(port), 8'(seq), 16'($urandom)});
    end
    plen[port].push_back(len);
    seq++;
  endtask

  // Reference model: serve every queued packet by the arbitration rules.
  task automatic build_expected();
    int cnt [NP];
    int off [NP];
    int pk  [NP];
    int g, len, idx, w;
    bit any, elig_any;
    for (int i = 0; i < NP; i++) begin
      cnt[i] = plen[i].size(); off[i] = 0; pk[i] = 0;
    end
    while (1) begin
      any = 0;
      for (int i = 0; i < NP; i++) if (cnt[i] > 0) any = 1;
      if (!any) break;
      g = -1;
      if (!sp0_wrr1) begin
        for (int i = 0; i < NP; i++)
          if (cnt[i] > 0 && (g < 0 || priority_p[i*PW +: PW] > priority_p[g*PW +: PW])) g = i;
      end else begin
        elig_any = 0;
        for (int i = 0; i < NP; i++) if (cnt[i] > 0 && m_credit[i] > 0) elig_any = 1;
        if (!elig_any)
          for (int i = 0; i < NP; i++) begin
            w = int'(weight_p[i*WW +: WW]);
            m_credit[i] = (w == 0) ? 1 : w;
          end
        for (int k = 0; k < NP; k++) begin
          idx = (m_ptr + k) % NP;
          if (g < 0 && cnt[idx] > 0 && m_credit[idx] > 0) g = idx;
        end
        m_credit[g]--;
        m_ptr = (m_credit[g] == 0) ? (g + 1) % NP : g;
      end
      len = plen[g][pk[g]];
      for (int j = 0; j < len; j++) exp_q.push_back(port_q[g][off[g] + j]);
      exp_port_q.push_back(g);
      off[g] += len; pk[g]++; cnt[g]--;
    end
    for (int i = 0; i < NP; i++) plen[i].delete();
  endtask

  // one clock: entered and left just after a falling edge with inputs driven
  task automatic step();
    logic [NP-1:0] popm, exp_nd;
    logic pop_any, pop_eop, m_busy_n, m_out_vld_n;
    logic [QW-1:0] w;
    #1;
    check("busy", busy, m_busy);
    check("out_vld", out_vld, m_out_vld);
    exp_nd = '0;
    if (m_busy) begin
      assert (exp_port_q.size() > 0) else begin
        n_fail++; $error("FAIL grant_queue observed=empty expected=packet");
      end
      if (exp_port_q.size() > 0) begin
        check("grant_port", grant_port, 64'(exp_port_q[0]));
        if (!m_out_vld || out_ready) exp_nd[exp_port_q[0]] = 1'b1;
      end
    end
    check("next_data", next_data, exp_nd);
    if (hold) check("out_hold", {out_vld, out_sop, out_eop, selected_data_out}, {1'b1, last_out});
    if (out_vld && out_ready) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++; $error("FAIL out_extra observed=%0h expected=none", selected_data_out);
      end
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("out_word", {out_sop, out_eop, selected_data_out}, w);
      end
    end
    popm        = next_data & vld;
    pop_any     = |popm;
    pop_eop     = |(popm & eop);
    m_out_vld_n = pop_any ? 1'b1 : (out_ready ? 1'b0 : m_out_vld);
    m_busy_n    = m_busy ? !pop_eop : (|ready);
    hold        = out_vld && !out_ready;
    last_out    = {out_sop, out_eop, selected_data_out};
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NP; i++)
      if (popm[i] && port_q[i].size() > 0) begin
        void'(port_q[i].pop_front());
        total_pops++;
      end
    if (pop_eop && exp_port_q.size() > 0) void'(exp_port_q.pop_front());
    m_busy    = m_busy_n;
    m_out_vld = m_out_vld_n;
    drive();
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++; $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_next_data", next_data, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_sop_eop", {out_sop, out_eop}, 0);
    check("rst_data", selected_data_out, 0);
    check("rst_grant", grant_port, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < NP; i++) begin
      port_q[i].delete(); plen[i].delete(); m_credit[i] = 0;
    end
    exp_q.delete(); exp_port_q.delete();
    m_ptr = 0; m_busy = 1'b0; m_out_vld = 1'b0; hold = 1'b0; bp_hold = 0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive();
  endtask

  initial begin
    int n;
    rst = 1'b1; sp0_wrr1 = 1'b0; priority_p = '0; weight_p = '0;
    for (int i = 0; i < NP; i++) m_credit[i] = 0;
    drive();
    #2;
    do_reset();

    // SP: ports 1 and 4, port 4 has the higher code
    sp0_wrr1 = 1'b0; bubble_pct = 0; bp_pct = 0;
    priority_p = '0;
    priority_p[1*PW +: PW] = 3'd2;
    priority_p[4*PW +: PW] = 3'd5;
    load_pkt(1, 3); load_pkt(4, 3);
    build_expected(); drive();
    run_drain(200);

    // SP ties: all ports ready with equal codes, lowest index first each time
    priority_p = '0;
    for (int i = 0; i < NP; i++) load_pkt(i, 1);
    build_expected(); drive();
    run_drain(300);

    // WRR: weights 2,1,3 on ports 0..2, single-word packets, two full rounds
    sp0_wrr1 = 1'b1;
    weight_p = '0;
    weight_p[0*WW +: WW] = 4'd2;
    weight_p[1*WW +: WW] = 4'd1;
    weight_p[2*WW +: WW] = 4'd3;
    for (int r = 0; r < 4; r++) load_pkt(0, 1);
    for (int r = 0; r < 2; r++) load_pkt(1, 1);
    for (int r = 0; r < 6; r++) load_pkt(2, 1);
    build_expected(); drive();
    run_drain(300);

    // Backpressure: out_ready held low for 3 cycles mid-packet
    sp0_wrr1 = 1'b0;
    load_pkt(7, 6);
    build_expected(); drive();
    step(); step(); step();
    bp_hold = 3;
    run_drain(200);

    // Reset in the middle of a 4-word WRR packet, then a fresh-credit round
    sp0_wrr1 = 1'b1;
    weight_p = '0;
    weight_p[0*WW +: WW] = 4'd3;
    weight_p[1*WW +: WW] = 4'd1;
    total_pops = 0;
    load_pkt(0, 4);
    build_expected(); drive();
    n = 0;
    while (total_pops < 2 && n < 50) begin
      step();
      n++;
    end
    do_reset();
    for (int r = 0; r < 6; r++) load_pkt(0, 1);
    for (int r = 0; r < 2; r++) load_pkt(1, 1);
    build_expected(); drive();
    run_drain(300);

    // Bubbles and single-word packets on one port
    sp0_wrr1 = 1'b0; bubble_pct = 50;
    load_pkt(9, 1); load_pkt(9, 3); load_pkt(9, 1); load_pkt(9, 2);
    build_expected(); drive();
    run_drain(300);

    // Random mixes of mode, codes, weights, lengths, bubbles and backpressure
    bubble_pct = 30; bp_pct = 30;
    for (int r = 0; r < 8; r++) begin
      sp0_wrr1 = 1'($urandom_range(1));
      for (int i = 0; i < NP; i++) begin
        priority_p[i*PW +: PW] = PW'($urandom_range(7));
        weight_p[i*WW +: WW]   = WW'($urandom_range(15));
      end
      n = $urandom_range(4, 12);
      for (int p = 0; p < n; p++) load_pkt($urandom_range(NP - 1), $urandom_range(1, 4));
      build_expected(); drive();
      run_drain(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
